// File: rtl/ps2_frame_rx_if.sv
// PS/2 receiver bus: raw PS/2 line inputs, received-byte outputs and
// an FSM state tap for checkers.
//
// Handshake: R_O is a valid-only strobe with no ready. It is high for exactly
// one clk cycle per completed frame. out and ERROR are valid in that cycle and
// hold until the next strobe. The consumer cannot apply backpressure.
interface ps2_frame_rx_if;
  logic       PS2_clk;
  logic       PS2_dat;
  logic [7:0] out;
  logic       R_O;
  logic       ERROR;
  logic [1:0] state_dbg;

  modport master (
    output PS2_clk,
    output PS2_dat,
    input  out,
    input  R_O,
    input  ERROR,
    input  state_dbg
  );

  modport slave (
    input  PS2_clk,
    input  PS2_dat,
    output out,
    output R_O,
    output ERROR,
    output state_dbg
  );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver. The raw PS/2 clock and data lines are synchronized.
// The clock is then deglitched, and each filtered falling edge clocks one bit of
// an 11-bit frame into the FSM: start, 8 data bits LSB-first, odd parity, stop.
// If the PS/2 clock stalls mid-frame, a watchdog drops the partial frame.
module ps2_frame_rx #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 5000
) (
  input  logic           clk,
  input  logic           rst_n,
  ps2_frame_rx_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  localparam logic [3:0]  FILT_LAST = 4'(FILTER_LEN - 1);
  localparam logic [15:0] TO_LIMIT  = 16'(TIMEOUT);

  // Synchronizers reset to 1, which is the PS/2 idle level.
  logic clk_s1, clk_s2;
  logic dat_s1, dat_s2;

  logic       filt_q;
  logic [3:0] filt_cnt;
  logic       fall;

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        par_err_q, par_err_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [7:0]  out_q, out_d;
  logic        err_q, err_d;
  logic        ro_q, ro_d;

  // Two-flop synchronizers for both asynchronous PS/2 lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= bus.PS2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= bus.PS2_dat;
      dat_s2 <= dat_s1;
    end
  end

  // Deglitch: follow the synchronized clock only after FILTER_LEN equal samples
  // of the new level. Raise a one-cycle fall pulse when the level drops to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q   <= 1'b1;
      filt_cnt <= 4'd0;
      fall     <= 1'b0;
    end else if (clk_s2 != filt_q) begin
      if (filt_cnt == FILT_LAST) begin
        filt_q   <= clk_s2;
        filt_cnt <= 4'd0;
        fall     <= ~clk_s2;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
        fall     <= 1'b0;
      end
    end else begin
      filt_cnt <= 4'd0;
      fall     <= 1'b0;
    end
  end

  // Frame FSM state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      par_err_q <= 1'b0;
      to_cnt_q  <= 16'd0;
      out_q     <= 8'h00;
      err_q     <= 1'b0;
      ro_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      par_err_q <= par_err_d;
      to_cnt_q  <= to_cnt_d;
      out_q     <= out_d;
      err_q     <= err_d;
      ro_q      <= ro_d;
    end
  end

  // Next-state, bit assembly, result strobe and stall watchdog
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    par_err_d = par_err_q;
    to_cnt_d  = to_cnt_q;
    out_d     = out_q;
    err_d     = err_q;
    ro_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall && !dat_s2) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d   = {dat_s2, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          // Odd parity: data plus parity bit must have an odd number of ones.
          par_err_d = ~(^shift_q ^ dat_s2);
          state_d   = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          ro_d    = 1'b1;
          out_d   = shift_q;
          err_d   = par_err_q | ~dat_s2;
        end
      end
      default: state_d = IDLE;
    endcase

    // The watchdog runs only while a frame is open. A fall in the same cycle
    // as expiry wins, so a late-but-valid bit still counts.
    if (state_q == IDLE) begin
      to_cnt_d = 16'd0;
    end else if (fall) begin
      to_cnt_d = 16'd0;
    end else if (to_cnt_q == TO_LIMIT) begin
      to_cnt_d = 16'd0;
      state_d  = IDLE;
    end else begin
      to_cnt_d = to_cnt_q + 16'd1;
    end
  end

  assign bus.out       = out_q;
  assign bus.R_O       = ro_q;
  assign bus.ERROR     = err_q;
  assign bus.state_dbg = state_q;

endmodule

// File: doc/ps2_frame_rx.md
PS2_FRAME_RX -- requirements
Module: ps2_frame_rx

Interface
REQ-001 FILTER_LEN, 4, number of consecutive equal clk samples needed before the filtered PS2_clk level changes; range 2..15.
REQ-002 TIMEOUT, 5000, number of clk cycles without a filtered PS2_clk falling edge after which a frame in progress is abandoned; range 16..65535.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 PS2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-006 PS2_dat  input  1  raw PS/2 data line, asynchronous to clk.
REQ-007 out  output  8  last received scan code byte.
REQ-008 R_O  output  1  one-cycle pulse: a complete frame has been received.
REQ-009 ERROR  output  1  status of the last completed frame: 1 = parity or stop-bit error.

Function
REQ-010 PS2_clk and PS2_dat SHALL each pass through a 2-flop synchronizer before any other use.
REQ-011 The filter SHALL change its output level only after the synchronized PS2_clk has held the new level for FILTER_LEN consecutive clk cycles; any shorter pulse SHALL be ignored.
REQ-012 A falling edge (fall) SHALL be the filtered level going 1->0; it SHALL last exactly one clk cycle, and the synchronized PS2_dat SHALL be sampled in that cycle.
REQ-013 The FSM SHALL have the states IDLE, DATA, PARITY and STOP.
REQ-014 In IDLE, a fall with sampled data 0 (start bit) SHALL go to DATA with bit count 0; a fall with data 1 SHALL be ignored, and the FSM SHALL stay in IDLE.
REQ-015 In DATA, each fall SHALL shift the sampled bit into a shift register LSB-first; after the 8th bit the FSM SHALL go to PARITY.
REQ-016 In PARITY, a fall SHALL capture the parity bit and go to STOP; parity SHALL be odd, so the 8 data bits plus the parity bit hold an odd number of ones.
REQ-017 In STOP, a fall SHALL capture the stop bit and go to IDLE; in the next clk cycle, R_O SHALL be 1 for exactly one cycle, out SHALL be loaded with the shifted byte, and ERROR SHALL be 1 if parity failed or the stop bit was 0, else 0.
REQ-018 out and ERROR SHALL be updated only when R_O is asserted, and SHALL hold their values until the next R_O.
REQ-019 A data byte SHALL be delivered on out even when ERROR=1.
REQ-020 A 16-bit timeout counter SHALL clear on every fall and increment in every other cycle while the FSM is outside IDLE.
REQ-021 When the timeout counter reaches TIMEOUT, the FSM SHALL return to IDLE with no R_O, and out and ERROR SHALL be unchanged.
REQ-022 The timeout counter SHALL be held at 0 in IDLE.
REQ-023 If a timeout and a fall occur in the same cycle, the fall SHALL take priority and the counter SHALL clear.
REQ-024 Minimum latency from the PS2_clk falling edge of the stop bit to R_O SHALL be 2 (synchronizer) + FILTER_LEN + 1 clk cycles; this number SHALL be fixed and documented in the bench.
REQ-025 Back-to-back frames with no idle time SHALL be received without loss.

Reset
REQ-026 While rst_n=0: FSM in IDLE, shift register 0, bit count 0, timeout counter 0, synchronizers 1, filtered level 1, out=8'h00, R_O=0, ERROR=0.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no R_O; after release, the first start bit SHALL begin a new frame.
REQ-028 Release of rst_n SHALL NOT by itself produce a fall.

Verification
REQ-029 Frame 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) -> one R_O pulse, out=8'h1C, ERROR=0.
REQ-030 Frame 0xF0 (parity 1, stop 1), then 0x1C sent back-to-back -> two R_O pulses, out=8'hF0 then 8'h1C, both with ERROR=0.
REQ-031 Frame 0x1C with parity 1 -> R_O pulse, out=8'h1C, ERROR=1; same frame with stop bit 0 -> R_O pulse, ERROR=1.
REQ-032 Start bit plus 5 data bits, then PS2_clk held high for TIMEOUT+10 cycles -> no R_O, out/ERROR unchanged; a following 0x1C frame is received correctly.
REQ-033 A 2-cycle low glitch on PS2_clk (FILTER_LEN=4) while idle and mid-frame -> no extra bit sampled, frame result unchanged.
REQ-034 rst_n pulsed low after 4 data bits -> outputs at reset values, no R_O; the next full 0xF0 frame gives out=8'hF0, ERROR=0.
